// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer and its song ROM format.
package note_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_END
   } seq_state_t;

   localparam logic [4:0] NOTE_REST = 5'd31;

   localparam int NOTE_MSB = 15;
   localparam int NOTE_LSB = 11;
   localparam int DUR_MSB  = 10;

   typedef struct packed {
      logic [NOTE_MSB-NOTE_LSB:0] note;
      logic [DUR_MSB:0]           dur;
   } song_word_t;

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// Prescaler producing a one-clock tick every DIV clocks; clear restarts the count at 0.
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || cnt == CNT_LAST)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/note_sequencer.sv
// Song player walking a {note, dur} ROM and driving the PWM note index.
// Build option NOTE_SEQ_LOOP_EN: end of song restarts at address 0 instead of stopping.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | silent, waiting for start
// S_FETCH | ROM address presented, waiting for registered read data
// S_LOAD  | ROM word sampled: end marker or new note
// S_PLAY  | note sounding, dur_cnt counts ticks down
// S_GAP   | articulation rest, gap_cnt counts ticks down
// S_END   | one-cycle done pulse, then back to idle
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 1000,
   parameter int ADDR_W    = 6,
   parameter int GAP_TICKS = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [4:0]        note,
   output logic              busy,
   output logic              done
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam logic [10:0] GAP_LOAD = 11'(GAP_TICKS);

`ifdef NOTE_SEQ_LOOP_EN
   localparam seq_state_t END_STATE = S_FETCH;
`else
   localparam seq_state_t END_STATE = S_END;
`endif

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [4:0]        note_nxt;
   logic              busy_nxt, done_nxt;
   logic [10:0]       dur_cnt, dur_nxt;
   logic [10:0]       gap_cnt, gap_nxt;

   song_word_t word;
   logic       tick, clear;
   logic       last_addr, note_over, gap_over, advance, end_evt, abort;

   assign word      = song_word_t'(rom_data);
   assign last_addr = (rom_addr == {ADDR_W{1'b1}});
   assign note_over = (state == S_PLAY) && tick && (dur_cnt == 11'd1);
   assign gap_over  = (state == S_GAP) && tick && (gap_cnt == 11'd1);
   assign advance   = gap_over || (note_over && GAP_TICKS == 0);
   assign end_evt   = ((state == S_LOAD) && (word.dur == '0)) || (advance && last_addr);
   assign abort     = stop && (state != S_IDLE);

   // Prescaler only runs while timing a note or gap, so every LOAD restarts it from 0.
   assign clear = (state != S_PLAY) && (state != S_GAP);

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rom_addr <= '0;
         note     <= NOTE_REST;
         busy     <= 1'b0;
         done     <= 1'b0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         rom_addr <= addr_nxt;
         note     <= note_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         dur_cnt  <= dur_nxt;
         gap_cnt  <= gap_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && !stop) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_LOAD;
         S_LOAD:  state_nxt = (word.dur == '0) ? END_STATE : S_PLAY;
         S_PLAY:  if (note_over) state_nxt = (GAP_TICKS > 0) ? S_GAP : (last_addr ? END_STATE : S_FETCH);
         S_GAP:   if (gap_over) state_nxt = last_addr ? END_STATE : S_FETCH;
         S_END:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_comb begin
      addr_nxt = rom_addr;
      note_nxt = note;
      busy_nxt = busy;
      done_nxt = 1'b0;
      dur_nxt  = dur_cnt;
      gap_nxt  = gap_cnt;
      case (state)
         S_IDLE: begin
            note_nxt = NOTE_REST;
            busy_nxt = 1'b0;
            if (start && !stop) begin
               addr_nxt = '0;
               busy_nxt = 1'b1;
            end
         end
         S_LOAD: begin
            if (word.dur != '0) begin
               note_nxt = word.note;
               dur_nxt  = word.dur;
               gap_nxt  = '0;
            end
         end
         S_PLAY: begin
            if (tick) begin
               dur_nxt = dur_cnt - 11'd1;
               if (dur_cnt == 11'd1 && GAP_TICKS > 0) begin
                  note_nxt = NOTE_REST;
                  gap_nxt  = GAP_LOAD;
               end
            end
         end
         S_GAP: begin
            if (tick) gap_nxt = gap_cnt - 11'd1;
         end
         S_END: begin
            note_nxt = NOTE_REST;
            busy_nxt = 1'b0;
         end
         default: ;
      endcase
      if (advance && !last_addr) addr_nxt = rom_addr + ADDR_W'(1);
      if (end_evt) begin
         done_nxt = 1'b1;
         note_nxt = NOTE_REST;
`ifdef NOTE_SEQ_LOOP_EN
         addr_nxt = '0;
`else
         busy_nxt = 1'b0;
`endif
      end
      if (abort) begin
         note_nxt = NOTE_REST;
         busy_nxt = 1'b0;
         done_nxt = 1'b0;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected note/busy/done events are queued with their cycle numbers.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [2:0]  rom_addr;
   logic [15:0] rom_data;
   logic [4:0]  note;
   logic        busy, done;

   logic [15:0] rom [8];

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] v;
      int         c;
   } ev_t;

   ev_t note_q[$];
   ev_t busy_q[$];
   int  done_q[$];

   note_sequencer #(
      .CLK_HZ   (1000),
      .TICK_HZ  (100),
      .ADDR_W   (3),
      .GAP_TICKS(2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .stop    (stop),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .note    (note),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rom_data <= rom[rom_addr];
   end

   // Monitor: every change on note/busy and every done-high cycle consumes one expected event.
   logic [4:0] prev_note = 5'd31;
   logic       prev_busy = 1'b0;
   always @(negedge clk) begin
      ev_t e;
      int  dc;
      if (note !== prev_note) begin
         checks++;
         if (note_q.size() == 0) begin
            errors++;
            $display("FAIL note_event: unexpected note %0d at cycle %0d", note, cyc);
         end else begin
            e = note_q.pop_front();
            if (e.v !== note || e.c != cyc) begin
               errors++;
               $display("FAIL note_event: got note %0d at cycle %0d, expected note %0d at cycle %0d",
                        note, cyc, e.v, e.c);
            end
         end
         prev_note = note;
      end
      if (busy !== prev_busy) begin
         checks++;
         if (busy_q.size() == 0) begin
            errors++;
            $display("FAIL busy_event: unexpected busy %0b at cycle %0d", busy, cyc);
         end else begin
            e = busy_q.pop_front();
            if (e.v[0] !== busy || e.c != cyc) begin
               errors++;
               $display("FAIL busy_event: got busy %0b at cycle %0d, expected busy %0b at cycle %0d",
                        busy, cyc, e.v[0], e.c);
            end
         end
         prev_busy = busy;
      end
      if (done === 1'b1) begin
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_pulse: unexpected done at cycle %0d", cyc);
         end else begin
            dc = done_q.pop_front();
            if (dc != cyc) begin
               errors++;
               $display("FAIL done_pulse: got done at cycle %0d, expected at cycle %0d", cyc, dc);
            end
         end
      end
   end

   task automatic exp_note(input logic [4:0] v, input int c);
      ev_t e;
      e.v = v;
      e.c = c;
      note_q.push_back(e);
   endtask

   task automatic exp_busy(input logic b, input int c);
      ev_t e;
      e.v = {4'b0, b};
      e.c = c;
      busy_q.push_back(e);
   endtask

   // Song {8,3},{12,1},{end}: note 8 from n+2, gap at n+32, FETCH/LOAD, note 12 at n+54, end marker loaded at n+86.
   task automatic expect_song1(input int n);
      exp_busy(1'b1, n);
      exp_note(5'd8, n + 2);
      exp_note(5'd31, n + 32);
      exp_note(5'd12, n + 54);
      exp_note(5'd31, n + 64);
      exp_busy(1'b0, n + 86);
      done_q.push_back(n + 86);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic check_empty(input string name);
      checks++;
      if (note_q.size() != 0 || busy_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL %s: events never seen: note %0d busy %0d done %0d",
                  name, note_q.size(), busy_q.size(), done_q.size());
         note_q.delete();
         busy_q.delete();
         done_q.delete();
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
      rom[0] = {5'd8, 11'd3};
      rom[1] = {5'd12, 11'd1};

      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("reset_note", int'(note), 31);
      check_val("reset_busy", int'(busy), 0);
      check_val("reset_done", int'(done), 0);
      check_val("reset_addr", int'(rom_addr), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Plain song with end marker
      @(negedge clk);
      n = cyc + 1;
      expect_song1(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(n + 95);
      check_empty("song1");
      check_val("song1_end_addr", int'(rom_addr), 2);

      // Start latency then abort mid-note
      @(negedge clk);
      n = cyc + 1;
      exp_busy(1'b1, n);
      exp_note(5'd8, n + 2);
      exp_note(5'd31, n + 12);
      exp_busy(1'b0, n + 12);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("start_addr_reset", int'(rom_addr), 0);
      wait_cyc(n + 11);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_cyc(n + 60);
      check_empty("stop_abort");

      // Replay after abort starts from address 0
      @(negedge clk);
      n = cyc + 1;
      expect_song1(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(n + 95);
      check_empty("replay");

      // start with stop while idle does nothing
      @(negedge clk);
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      repeat (5) @(negedge clk);
      check_val("start_stop_busy", int'(busy), 0);
      check_val("start_stop_note", int'(note), 31);

      // start during PLAY is ignored
      @(negedge clk);
      n = cyc + 1;
      expect_song1(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(n + 9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(n + 95);
      check_empty("start_in_play");

      // Async reset during the second gap (rom_addr=1)
      @(negedge clk);
      n = cyc + 1;
      exp_busy(1'b1, n);
      exp_note(5'd8, n + 2);
      exp_note(5'd31, n + 32);
      exp_note(5'd12, n + 54);
      exp_note(5'd31, n + 64);
      exp_busy(1'b0, n + 70);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(n + 69);
      check_val("gap_addr_before_reset", int'(rom_addr), 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("async_note", int'(note), 31);
      check_val("async_busy", int'(busy), 0);
      check_val("async_done", int'(done), 0);
      check_val("async_addr", int'(rom_addr), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check_empty("async_reset");

      // Full ROM, no end marker: each entry is 2 + 10 + 20 clocks
      for (int k = 0; k < 8; k++) rom[k] = {5'(k + 1), 11'd1};
      @(negedge clk);
      n = cyc + 1;
      exp_busy(1'b1, n);
      for (int k = 0; k < 8; k++) begin
         exp_note(5'(k + 1), n + 2 + 32 * k);
         exp_note(5'd31, n + 12 + 32 * k);
      end
      done_q.push_back(n + 256);
`ifdef NOTE_SEQ_LOOP_EN
      exp_note(5'd1, n + 258);
      exp_note(5'd31, n + 268);
      exp_busy(1'b0, n + 270);
`else
      exp_busy(1'b0, n + 256);
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
      wait_cyc(n + 259);
      check_val("loop_addr", int'(rom_addr), 0);
      check_val("loop_busy", int'(busy), 1);
      wait_cyc(n + 269);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
`else
      wait_cyc(n + 258);
      check_val("full_rom_addr", int'(rom_addr), 7);
`endif
      wait_cyc(n + 290);
      check_empty("full_rom");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Song player that drives the 5-bit `note` index consumed by the PWM audio generator. It walks a song ROM of {note, duration} entries and holds each note for an exact number of millisecond ticks. Between notes it inserts a short rest (note 31 = silence) so repeated notes articulate. It sits between game-event control logic (start/stop) and the audio PWM block.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 1000, duration-unit rate; DIV = CLK_HZ/TICK_HZ clocks per tick, must be ≥2.
ADDR_W, 6, song ROM address width; depth = 2**ADDR_W entries.
GAP_TICKS, 20, silent ticks inserted after each note; 0 disables the gap.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle request to play the song from address 0
stop  in  1  synchronous abort; silences output
rom_addr  out  ADDR_W  song ROM read address
rom_data  in  16  ROM word {note[15:11], dur[10:0]}; registered ROM, data valid one clk after rom_addr
note  out  5  note index to the PWM generator; 31 = silence
busy  out  1  high from start acceptance until the song ends or is aborted
done  out  1  1-cycle pulse on natural end of song

Behaviour:
- Reset (async): state IDLE, note=31, busy=0, done=0, rom_addr=0, all counters 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP, END.
- IDLE: note=31, busy=0. When start=1 and stop=0: rom_addr<=0, busy<=1, go to FETCH. start is ignored in every other state.
- FETCH: one wait cycle for the ROM. Go to LOAD.
- LOAD: sample rom_data.
  - If dur==0, the entry is an end marker: go to END.
  - Otherwise: note<=rom_data[15:11], dur_cnt<=dur, prescaler<=0, go to PLAY.
- Latency: if start is sampled at edge N, note is updated at edge N+2.
- PLAY:
  - The prescaler counts 0..DIV-1; a tick fires when it wraps.
  - Each tick decrements dur_cnt.
  - On the tick that takes dur_cnt to 0: if GAP_TICKS>0, note<=31, gap_cnt<=GAP_TICKS, go to GAP; else go to advance.
  - A note lasts exactly dur×DIV clocks.
- GAP: note=31; tick-decrement gap_cnt; on reaching 0, go to advance. The gap lasts GAP_TICKS×DIV clocks.
- Advance:
  - If rom_addr == 2**ADDR_W−1, go to END. There is no wrap-around; this is an implicit end of song.
  - Otherwise rom_addr<=rom_addr+1, go to FETCH.
- END: note=31, done=1 for exactly one cycle, busy<=0, go to IDLE.
- stop=1 in any non-IDLE state: next edge note=31, busy=0, state IDLE, no done pulse. stop wins over start and over any simultaneous tick or end event.
- A dur value with a note of 31 is a legal timed rest.
- The prescaler and counters are cleared on every LOAD, so timing is independent of prior history.
- Widths: dur_cnt is 11 bits and gap_cnt is 11 bits; the prescaler is $clog2(DIV) bits.

Optional Feature:
NOTE_SEQ_LOOP_EN.
- Defined: an end marker or the last address restarts playback at address 0 (rom_addr<=0, go to FETCH). done pulses once per loop, busy stays 1, and only stop returns to IDLE.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package note_seq_pkg holds:
  - the state enum;
  - NOTE_REST = 5'd31;
  - ROM field slice constants (NOTE_MSB=15, NOTE_LSB=11, DUR_MSB=10);
  - the song-word typedef.
- Sub-module tick_gen (parameter DIV; ports clk, reset, clear, tick) owns the prescaler. It is reused by other timed blocks.

Test Plan (CLK_HZ=1000, TICK_HZ=100 ⇒ DIV=10, GAP_TICKS=2, ADDR_W=3):
1. ROM {note 8, dur 3}, {note 12, dur 1}, {0,0}; pulse start → note=8 for 30 clks, 31 for 20, 12 for 10, 31 for 20. done pulses once, busy falls on the same edge.
2. Start at edge N → rom_addr=0 after N, note=8 after N+2, busy=1 after N.
3. stop asserted mid-note 8 → note=31 and busy=0 next edge, no done. A new start then replays from address 0.
4. start and stop in the same cycle while IDLE → stays IDLE, note=31, busy=0. start pulsed during PLAY is ignored; timing is unchanged.
5. All 8 ROM entries are nonzero with no end marker → the song ends after entry 7 with a done pulse. With NOTE_SEQ_LOOP_EN it restarts at address 0 and busy stays 1.
6. Assert reset asynchronously mid-GAP (between clk edges) → note=31, busy=0, done=0, rom_addr=0 immediately.
